pot_poll_master: RTL and testbench

- Avalon-MM master that periodically reads the 8-bit potentiometer input PIO (register 0) and produces a filtered paddle position for the Ping-Pong game logic.
- Polls at a fixed interval and applies a power-of-two moving average.
- Emits a one-cycle strobe per new position, plus a change flag.
- Sits between the interconnect (master side of the PIO slave) and the paddle/game controller.

---
 rtl/pot_poll_pkg.sv | 18 +
 rtl/pot_avg_filter.sv | 59 +++++
 rtl/pot_poll_master.sv | 100 ++++++++++
 tb/tb_pot_poll_master.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/pot_poll_pkg.sv
// Shared types and constants for the potentiometer polling master.
package pot_poll_pkg;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT_DATA,
      FILTER
   } state_e;

   localparam int DATA_W = 8;

   // Running-sum width: a full buffer of max samples fits without overflow.
   function automatic int sum_width(input int avg_log2);
      return DATA_W + avg_log2;
   endfunction

endpackage

// File: rtl/pot_avg_filter.sv
// Power-of-two moving average over the last 2^AVG_LOG2 samples.
// The filter uses a ring buffer and a running sum, and emits one-cycle valid/changed strobes.
module pot_avg_filter
   import pot_poll_pkg::*;
#(
   parameter int AVG_LOG2 = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              sample_valid,
   input  logic [DATA_W-1:0] sample,
   output logic [DATA_W-1:0] pos,
   output logic              pos_valid,
   output logic              pos_changed
);

   localparam int DEPTH = 1 << AVG_LOG2;
   localparam int SUM_W = sum_width(AVG_LOG2);
   localparam int PTR_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

   logic [DATA_W-1:0] ring_q [DEPTH];
   logic [SUM_W-1:0]  sum_q, sum_d;
   logic [PTR_W-1:0]  ptr_q, ptr_d;
   logic [DATA_W-1:0] pos_q, pos_d;
   logic              pos_valid_q;
   logic              pos_changed_q;

   // Intermediate may wrap below zero, but the final sum is always in range.
   always_comb begin
      sum_d = sum_q + SUM_W'(sample) - SUM_W'(ring_q[ptr_q]);
      pos_d = DATA_W'(sum_d >> AVG_LOG2);
      ptr_d = (ptr_q == PTR_W'(DEPTH - 1)) ? '0 : ptr_q + PTR_W'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) ring_q[i] <= '0;
         sum_q         <= '0;
         ptr_q         <= '0;
         pos_q         <= '0;
         pos_valid_q   <= 1'b0;
         pos_changed_q <= 1'b0;
      end else begin
         pos_valid_q   <= sample_valid;
         pos_changed_q <= sample_valid && (pos_d != pos_q);
         if (sample_valid) begin
            ring_q[ptr_q] <= sample;
            sum_q         <= sum_d;
            ptr_q         <= ptr_d;
            pos_q         <= pos_d;
         end
      end
   end

   assign pos         = pos_q;
   assign pos_valid   = pos_valid_q;
   assign pos_changed = pos_changed_q;

endmodule

// File: rtl/pot_poll_master.sv
// Avalon-MM master that periodically reads the potentiometer PIO.
// The sampled values are fed to a moving-average filter that produces the paddle position.
module pot_poll_master
   import pot_poll_pkg::*;
#(
   parameter int POLL_CYCLES  = 50000,
   parameter int READ_LATENCY = 1,
   parameter int AVG_LOG2     = 2,
   parameter int PIO_ADDR     = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   output logic [1:0]        avm_address,
   output logic              avm_read,
   input  logic              avm_waitrequest,
   input  logic [31:0]       avm_readdata,
   output logic [DATA_W-1:0] pos,
   output logic              pos_valid,
   output logic              pos_changed
);

   localparam int CNT_W = $clog2(POLL_CYCLES);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [1:0]        lat_q, lat_d;
   logic [DATA_W-1:0] sample_q, sample_d;

   // Only the low byte of the PIO register carries the pot reading.
   logic unused_rdata;
   assign unused_rdata = ^avm_readdata[31:DATA_W];

   assign avm_address = 2'(PIO_ADDR);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         lat_q    <= '0;
         sample_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         lat_q    <= lat_d;
         sample_q <= sample_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      lat_d    = lat_q;
      sample_d = sample_q;
      avm_read = 1'b0;
      case (state_q)
         IDLE: begin
            if (!enable) begin
               cnt_d = '0;
            end else if (cnt_q == CNT_W'(POLL_CYCLES - 1)) begin
               cnt_d   = '0;
               state_d = REQ;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         REQ: begin
            avm_read = 1'b1;
            if (!avm_waitrequest) begin
               lat_d   = '0;
               state_d = WAIT_DATA;
            end
         end
         WAIT_DATA: begin
            // Slave latency is fixed, so data is taken on the last latency cycle.
            if (lat_q == 2'(READ_LATENCY - 1)) begin
               sample_d = avm_readdata[DATA_W-1:0];
               state_d  = FILTER;
            end else begin
               lat_d = lat_q + 2'd1;
            end
         end
         FILTER:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   pot_avg_filter #(
      .AVG_LOG2 (AVG_LOG2)
   ) u_filter (
      .clk          (clk),
      .reset        (reset),
      .sample_valid (state_q == FILTER),
      .sample       (sample_q),
      .pos          (pos),
      .pos_valid    (pos_valid),
      .pos_changed  (pos_changed)
   );

endmodule

// File: tb/tb_pot_poll_master.sv
// Directed + randomized bench for pot_poll_master with a sliding-window average model.
module tb_pot_poll_master;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, en, wr;
   logic [7:0]  pio;
   logic [31:0] rdata;
   logic [1:0]  addr;
   logic        rd, pv, pc;
   logic [7:0]  pos;

   logic        en2;
   logic [1:0]  addr2;
   logic        rd2, pv2, pc2;
   logic [31:0] rdata2;
   logic [7:0]  pos2;
   int          seq2;

   int          vecs = 0;
   int          errs = 0;
   int          hist[$];
   logic [7:0]  prev_pos;

   pot_poll_master #(.POLL_CYCLES(10), .READ_LATENCY(1), .AVG_LOG2(2), .PIO_ADDR(0)) u_dut (
      .clk(clk), .reset(reset), .enable(en),
      .avm_address(addr), .avm_read(rd), .avm_waitrequest(wr), .avm_readdata(rdata),
      .pos(pos), .pos_valid(pv), .pos_changed(pc));

   pot_poll_master #(.POLL_CYCLES(4), .READ_LATENCY(3), .AVG_LOG2(0), .PIO_ADDR(0)) u_lat (
      .clk(clk), .reset(reset), .enable(en2),
      .avm_address(addr2), .avm_read(rd2), .avm_waitrequest(1'b0), .avm_readdata(rdata2),
      .pos(pos2), .pos_valid(pv2), .pos_changed(pc2));

   // Slave 1: data valid only in the cycle after acceptance, garbage otherwise.
   always @(posedge clk) begin
      if (rd && !wr) rdata <= {24'($urandom), pio};
      else           rdata <= $urandom;
   end

   // Slave 2: a new value every cycle after acceptance (0x11, 0x22, 0x33, ...).
   always @(posedge clk) begin
      if (reset)                     seq2 <= 0;
      else if (rd2)                  seq2 <= 1;
      else if (seq2 > 0 && seq2 < 4) seq2 <= seq2 + 1;
   end
   assign rdata2 = {24'h0, 8'(seq2 * 17)};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vecs++;
      assert (obs === expv) else begin
         errs++;
         $error("FAIL %s: got %0h want %0h", tag, obs, expv);
      end
   endtask

   task automatic model_reset();
      hist     = {0, 0, 0, 0};
      prev_pos = 8'h00;
   endtask

   // One full poll: wait for the request, stall it, then check the strobe.
   task automatic do_poll(input int stall, input logic [7:0] val, input int exp_wait, input bit drop_en);
      int         n, npv, sum;
      logic [7:0] ep;
      n   = 0;
      npv = 0;
      sum = 0;
      pio = val;
      wr  = (stall > 0);
      do begin
         @(negedge clk);
         n++;
         npv += int'(pv);
      end while (rd !== 1'b1 && n < 40);
      chk("req_wait", n, exp_wait);
      chk("early_pv", npv, 0);
      for (int i = 0; i <= stall; i++) begin
         if (i > 0) @(negedge clk);
         chk("rd_held", rd, 1);
         chk("addr", addr, 0);
         if (i == stall) wr = 1'b0;
      end
      @(negedge clk);
      chk("rd_drop", rd, 0);
      if (drop_en) en = 1'b0;
      @(negedge clk);
      chk("pv_filter", pv, 0);
      @(negedge clk);
      hist.push_back(int'(val));
      void'(hist.pop_front());
      foreach (hist[k]) sum += hist[k];
      ep = 8'(sum / 4);
      chk("pv", pv, 1);
      chk("pos", pos, ep);
      chk("pc", pc, (ep != prev_pos));
      prev_pos = ep;
      @(negedge clk);
      chk("pv_pulse", pv, 0);
   endtask

   initial begin
      int n, nrd, npv;
      reset = 1'b1;
      en    = 1'b0;
      en2   = 1'b0;
      wr    = 1'b0;
      pio   = 8'h00;
      repeat (3) @(negedge clk);
      chk("rst_rd", rd, 0);
      chk("rst_addr", addr, 0);
      chk("rst_pos", pos, 0);
      chk("rst_pv", pv, 0);
      chk("rst_pc", pc, 0);
      chk("rst_rd2", rd2, 0);
      reset = 1'b0;
      model_reset();

      // Constant 0x80: ramp 20,40,60,80 then steady.
      en = 1'b1;
      do_poll(0, 8'h80, 10, 0);
      repeat (4) do_poll(0, 8'h80, 9, 0);

      do_poll(5, 8'($urandom), 9, 0);

      // Clean buffer for the saturation sequence.
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      do_poll(0, 8'hFF, 10, 0);
      repeat (3) do_poll(0, 8'hFF, 9, 0);
      do_poll(0, 8'h00, 9, 0);

      for (int k = 0; k < 12; k++) do_poll(int'($urandom_range(0, 3)), 8'($urandom), 9, 0);

      // Drop enable while waiting for data.
      do_poll(0, 8'($urandom), 9, 1);
      nrd = 0;
      npv = 0;
      repeat (50) begin
         @(negedge clk);
         nrd += int'(rd);
         npv += int'(pv);
      end
      chk("off_rd", nrd, 0);
      chk("off_pv", npv, 0);
      en = 1'b1;
      do_poll(0, 8'($urandom), 10, 0);

      // Reset while the request is stalled.
      wr  = 1'b1;
      pio = 8'($urandom);
      n   = 0;
      do begin
         @(negedge clk);
         n++;
      end while (rd !== 1'b1 && n < 20);
      chk("mid_req", rd, 1);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("mid_rst_rd", rd, 0);
      chk("mid_rst_pos", pos, 0);
      chk("mid_rst_pv", pv, 0);
      wr = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      do_poll(0, 8'($urandom), 10, 0);

      // Long-latency instance: the third post-acceptance value is taken.
      en  = 1'b0;
      en2 = 1'b1;
      for (int p = 0; p < 2; p++) begin
         n = 0;
         do begin
            @(negedge clk);
            n++;
         end while (rd2 !== 1'b1 && n < 20);
         chk("lat_req_wait", n, 4);
         n = 0;
         do begin
            @(negedge clk);
            n++;
         end while (pv2 !== 1'b1 && n < 20);
         chk("lat_pv_delay", n, 5);
         chk("lat_pos", pos2, 8'h33);
         chk("lat_pc", pc2, (p == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
